// File: rtl/uart_rx_v_2.sv
// rtl/uart_rx_v_2.sv - UART serial receiver: start/data/even-parity/stop frame to a valid/ack word interface
module uart_rx_v_2 #(
    parameter int CLKRATE     = 50_000_000,
    parameter int BAUD        = 9600,
    parameter int WORD_LENGTH = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   UART_Rx_IN,
    input  logic                   UART_Rx_ACK,
    output logic [WORD_LENGTH-1:0] Rx_DATA,
    output logic                   UART_Rx_VALID,
    output logic                   UART_Rx_PARITY_ERR,
    output logic                   UART_Rx_FRAME_ERR,
    output logic                   UART_Rx_OVERRUN,
    output logic                   UART_Rx_BUSY
);
    localparam int BIT_CYCLES = CLKRATE / BAUD + 1;
    localparam int HALF       = BIT_CYCLES / 2;
    localparam int CW         = (BIT_CYCLES > 2) ? $clog2(BIT_CYCLES) : 1;
    localparam int BW         = (WORD_LENGTH > 1) ? $clog2(WORD_LENGTH) : 1;
    localparam logic [CW-1:0] CNT_LAST  = CW'(BIT_CYCLES - 1);
    localparam logic [CW-1:0] HALF_LAST = CW'(HALF - 1);
    localparam logic [CW-1:0] CNT_ONE   = CW'(1);
    localparam logic [BW-1:0] BIT_LAST  = BW'(WORD_LENGTH - 1);
    localparam logic [BW-1:0] BIT_ONE   = BW'(1);

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

    state_t                 state, state_nxt;
    logic                   sync1, sync2, sync_prev;
    logic                   fall;
    logic [CW-1:0]          cnt, cnt_nxt;
    logic [BW-1:0]          bit_cnt, bit_nxt;
    logic [WORD_LENGTH-1:0] shift;
    logic                   par_err_r, frm_err_r, stop_done;
    logic                   bit_end, commit;

    assign fall         = ~sync2 & sync_prev;
    assign bit_end      = (cnt == CNT_LAST);
    assign UART_Rx_BUSY = (state != IDLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            cnt     <= '0;
            bit_cnt <= '0;
        end else begin
            state   <= state_nxt;
            cnt     <= cnt_nxt;
            bit_cnt <= bit_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = bit_end ? '0 : cnt + CNT_ONE;
        bit_nxt   = bit_cnt;
        commit    = 1'b0;
        case (state)
            IDLE: begin
                cnt_nxt = '0;
                bit_nxt = '0;
                if (fall) state_nxt = START;
            end
            START: begin
                if (cnt == HALF_LAST) begin
                    cnt_nxt   = '0;
                    state_nxt = sync2 ? IDLE : DATA;
                end
            end
            DATA: begin
                if (bit_end) begin
                    if (bit_cnt == BIT_LAST) begin
                        bit_nxt   = '0;
                        state_nxt = PARITY;
                    end else begin
                        bit_nxt = bit_cnt + BIT_ONE;
                    end
                end
            end
            PARITY: begin
                if (bit_end) state_nxt = STOP;
            end
            STOP: begin
                // stop bit was captured last cycle; deliver and rearm mid-stop
                if (stop_done) begin
                    commit    = 1'b1;
                    cnt_nxt   = '0;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1              <= 1'b1;
            sync2              <= 1'b1;
            sync_prev          <= 1'b1;
            shift              <= '0;
            par_err_r          <= 1'b0;
            frm_err_r          <= 1'b0;
            stop_done          <= 1'b0;
            Rx_DATA            <= '0;
            UART_Rx_VALID      <= 1'b0;
            UART_Rx_PARITY_ERR <= 1'b0;
            UART_Rx_FRAME_ERR  <= 1'b0;
            UART_Rx_OVERRUN    <= 1'b0;
        end else begin
            sync1     <= UART_Rx_IN;
            sync2     <= sync1;
            sync_prev <= sync2;
            stop_done <= (state == STOP) && bit_end && !stop_done;
            if (state == DATA && bit_end) shift[bit_cnt] <= sync2;
            if (state == PARITY && bit_end) par_err_r <= sync2 ^ (^shift);
            if (state == STOP && bit_end && !stop_done) frm_err_r <= ~sync2;
            if (commit) begin
                Rx_DATA            <= shift;
                UART_Rx_PARITY_ERR <= par_err_r;
                UART_Rx_FRAME_ERR  <= frm_err_r;
                UART_Rx_VALID      <= 1'b1;
                UART_Rx_OVERRUN    <= UART_Rx_VALID & ~UART_Rx_ACK;
            end else if (UART_Rx_ACK && UART_Rx_VALID) begin
                UART_Rx_VALID   <= 1'b0;
                UART_Rx_OVERRUN <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_uart_rx_v_2.sv
// tb/tb_uart_rx_v_2.sv - scoreboard bench for uart_rx_v_2 with a bit-level serial frame driver
module tb_uart_rx_v_2;
    logic       clk = 1'b0;
    logic       rst;
    logic       rx;
    logic       ack;
    logic [7:0] rx_data;
    logic       valid, perr, ferr, ovr, busy;

    typedef struct packed {
        logic [7:0] d;
        logic       pe;
        logic       fe;
        logic       ov;
    } exp_t;

    exp_t sb[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    logic busy_q  = 1'b0;
    logic busy_seen;
    logic b2, b3;

    uart_rx_v_2 #(.CLKRATE(15), .BAUD(1), .WORD_LENGTH(8)) dut (
        .clk               (clk),
        .rst               (rst),
        .UART_Rx_IN        (rx),
        .UART_Rx_ACK       (ack),
        .Rx_DATA           (rx_data),
        .UART_Rx_VALID     (valid),
        .UART_Rx_PARITY_ERR(perr),
        .UART_Rx_FRAME_ERR (ferr),
        .UART_Rx_OVERRUN   (ovr),
        .UART_Rx_BUSY      (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic observe(input int c);
        exp_t e;
        if (busy_q && !busy && valid && !rst) begin
            if (sb.size() == 0) begin
                check("unexpected_commit", 32'd1, 32'd0);
            end else begin
                e = sb.pop_front();
                check("rx_data", rx_data, e.d);
                check("parity_err", perr, e.pe);
                check("frame_err", ferr, e.fe);
                check("overrun", ovr, e.ov);
                check("commit_cycle", c, 172);
            end
        end
        busy_q = busy;
    endtask

    // frame = start, 8 data LSB first, even parity (optionally flipped), stop
    task automatic send_frame(input logic [7:0] d, input logic pflip, input logic stopb,
                              input logic ack_commit, input logic exp_ovr, input int ncyc);
        logic [10:0] fr;
        exp_t e;
        fr = {stopb, (^d) ^ pflip, d, 1'b0};
        if (ncyc >= 176) begin
            e.d = d; e.pe = pflip; e.fe = ~stopb; e.ov = exp_ovr;
            sb.push_back(e);
        end
        for (int c = 0; c < ncyc; c++) begin
            @(negedge clk);
            observe(c);
            if (c == 2) b2 = busy;
            if (c == 3) b3 = busy;
            rx  = fr[c/16];
            ack = ack_commit && (c == 171);
        end
    endtask

    task automatic idle(input int n, input logic v);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            observe(-1);
            rx  = v;
            ack = 1'b0;
            busy_seen |= busy;
        end
    endtask

    task automatic ack_pulse();
        @(negedge clk);
        observe(-1);
        ack = 1'b1;
        @(negedge clk);
        observe(-1);
        ack = 1'b0;
    endtask

    initial begin
        logic [7:0] w;
        rst = 1'b1; rx = 1'b1; ack = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_data", rx_data, 0);
        check("rst_valid", valid, 0);
        check("rst_flags", {perr, ferr, ovr}, 0);
        check("rst_busy", busy, 0);
        rst = 1'b0;
        idle(20, 1'b1);

        send_frame(8'hA5, 1'b0, 1'b1, 1'b0, 1'b0, 176);
        check("busy_before_start", b2, 0);
        check("busy_at_start", b3, 1);
        check("valid_after_a5", valid, 1);
        ack_pulse();
        check("valid_after_ack", valid, 0);
        check("data_held_after_ack", rx_data, 8'hA5);
        idle(10, 1'b1);

        send_frame(8'h01, 1'b1, 1'b1, 1'b0, 1'b0, 176);
        check("valid_parity_frame", valid, 1);
        idle(5, 1'b1);

        send_frame(8'h5A, 1'b0, 1'b1, 1'b0, 1'b0, 60);
        check("busy_mid_frame", busy, 1);
        #2 rst = 1'b1;
        #1;
        check("arst_data", rx_data, 0);
        check("arst_valid", valid, 0);
        check("arst_flags", {perr, ferr, ovr}, 0);
        check("arst_busy", busy, 0);
        @(negedge clk);
        rst = 1'b0; rx = 1'b1; busy_q = 1'b0;
        idle(200, 1'b1);
        check("no_valid_after_rst", valid, 0);

        send_frame(8'h3C, 1'b0, 1'b0, 1'b0, 1'b0, 176);
        busy_seen = 1'b0;
        idle(300, 1'b0);
        check("stuck_low_no_rx", busy_seen, 0);
        idle(20, 1'b1);
        send_frame(8'h5A, 1'b0, 1'b1, 1'b1, 1'b0, 176);
        ack_pulse();
        idle(10, 1'b1);

        busy_seen = 1'b0;
        idle(4, 1'b0);
        idle(40, 1'b1);
        check("false_start_busy", busy_seen, 1);
        check("false_start_valid", valid, 0);
        check("false_start_idle", busy, 0);

        send_frame(8'h11, 1'b0, 1'b1, 1'b0, 1'b0, 176);
        send_frame(8'h22, 1'b0, 1'b1, 1'b0, 1'b1, 176);
        check("overrun_valid", valid, 1);
        ack_pulse();
        check("overrun_ack_valid", valid, 0);
        check("overrun_ack_flag", ovr, 0);
        send_frame(8'h33, 1'b0, 1'b1, 1'b0, 1'b0, 176);
        send_frame(8'h44, 1'b0, 1'b1, 1'b1, 1'b0, 176);
        check("ack_commit_valid", valid, 1);
        ack_pulse();
        idle(5, 1'b1);

        for (int i = 0; i < 8; i++) begin
            w = 8'($urandom_range(0, 255));
            send_frame(w, 1'b0, 1'b1, 1'b1, 1'b0, 176);
        end
        idle(10, 1'b1);
        check("scoreboard_drained", sb.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
